// File: rtl/uart_rx_rtl.sv
// UART receiver: 1 start bit, N data bits LSB-first, no parity, 1 stop bit.
// The line is double-synchronised, a start is recognised only on a falling
// edge, and every bit is sampled near its middle using a counter that is
// re-centred at the middle of the start bit.
module uart_rx_rtl #(
  parameter int N        = 8,
  parameter int BR       = 9600,
  parameter int CLK_FREQ = 50000000
) (
  input  logic         i_clk,
  input  logic         rst,
  input  logic         rx,
  output logic [N-1:0] o_data,
  output logic         o_dv,
  output logic         frame_err,
  output logic         rx_busy
);

  localparam int CPB  = CLK_FREQ / BR;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int BW   = (N > 2) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(N - 1);

  // Reject bit periods too short to find a start-bit midpoint, and word
  // sizes the shift register cannot represent.
  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx_rtl: CLK_FREQ/BR = %0d, must be at least 4", CPB);
  end
  if (N < 2) begin : g_n_check
    $error("uart_rx_rtl: N = %0d, must be at least 2", N);
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA_BITS = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  idx_q, idx_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [N-1:0]   data_q, data_d;
  logic           dv_q, dv_d;
  logic           fe_q, fe_d;

  logic           rx_meta_q;
  logic           rx_s_q;
  logic           rx_prev_q;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection;
  // all three reset to the idle (high) line level so reset cannot fake a start.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
    end
  end

  // Next-state logic; the counter restarts on every transition and after each
  // data-bit sample so that it never relies on natural wrap-around.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA_BITS;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA_BITS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[N-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s_q) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            fe_d   = 1'b1;
          end
        end
      end
      CLEANUP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_data    = data_q;
  assign o_dv      = dv_q;
  assign frame_err = fe_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_rtl.sv
// Directed testbench for uart_rx_rtl at CLK_FREQ=160, BR=10 (16 clocks/bit).
module tb_uart_rx_rtl;

  localparam int N        = 8;
  localparam int BR       = 10;
  localparam int CLK_FREQ = 160;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx  = 1'b1;
  logic [N-1:0] o_data;
  logic         o_dv;
  logic         frame_err;
  logic         rx_busy;

  int errors = 0;
  int checks = 0;

  uart_rx_rtl #(.N(N), .BR(BR), .CLK_FREQ(CLK_FREQ)) dut (
    .i_clk    (clk),
    .rst      (rst),
    .rx       (rx),
    .o_data   (o_data),
    .o_dv     (o_dv),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  // Rising-edge count used as a time base for latency measurement.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  int         dv_cnt   = 0;
  int         fe_cnt   = 0;
  int         busy_cnt = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  int         dv_cyc   = 0;
  logic [7:0] dv_log [0:15];
  logic       prev_dv  = 1'b0;
  logic       prev_fe  = 1'b0;

  always @(negedge clk) begin
    if (o_dv === 1'b1) begin
      if (dv_cnt < 16) dv_log[dv_cnt] = o_data;
      dv_cnt++;
      dv_cyc = cyc;
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (rx_busy === 1'b1) busy_cnt++;
    if (o_dv === 1'b1 && frame_err === 1'b1) both_cnt++;
    if ((o_dv === 1'b1 && prev_dv) || (frame_err === 1'b1 && prev_fe)) long_cnt++;
    prev_dv = (o_dv === 1'b1);
    prev_fe = (frame_err === 1'b1);
  end

  // Drive one frame starting at a falling clock edge. per100 is the bit period
  // in hundredths of a clock, so 1632 is +2% slow and 1568 is 2% fast.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int per100);
    logic [9:0] bits;
    bits = {stop_b, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      int n;
      n  = ((k + 1) * per100 + 50) / 100 - (k * per100 + 50) / 100;
      rx = bits[k];
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int dv0, fe0, b0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_o_data: got %h expected 00", o_data); end
    checks++; if (o_dv !== 1'b0) begin errors++; $display("FAIL reset_o_dv: got %b expected 0", o_dv); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    rst = 1'b0;
    dv0 = dv_cnt; fe0 = fe_cnt; b0 = busy_cnt;
    repeat (100) @(negedge clk);
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL idle_dv: got %0d pulses expected 0", dv_cnt - dv0); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL idle_fe: got %0d pulses expected 0", fe_cnt - fe0); end
    checks++; if (busy_cnt - b0 !== 0) begin errors++; $display("FAIL idle_busy: got %0d busy cycles expected 0", busy_cnt - b0); end
  endtask

  task automatic test_basic();
    int dv0, fe0, fall_cyc, lat;
    dv0 = dv_cnt; fe0 = fe_cnt;
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1600);
    repeat (20) @(negedge clk);
    lat = dv_cyc - fall_cyc;
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL basic_dv_count: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", o_data); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL basic_fe: got %0d expected 0", fe_cnt - fe0); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", rx_busy); end
    checks++; if (lat < 155 || lat > 157) begin errors++; $display("FAIL basic_latency: got %0d cycles expected 155..157", lat); end
  endtask

  task automatic test_false_start();
    int dv0, fe0, b0;
    dv0 = dv_cnt; fe0 = fe_cnt; b0 = busy_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (busy_cnt - b0 <= 0) begin errors++; $display("FAIL false_busy_seen: got %0d busy cycles expected >0", busy_cnt - b0); end
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL false_dv: got %0d expected 0", dv_cnt - dv0); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL false_fe: got %0d expected 0", fe_cnt - fe0); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL false_data: got %h expected a5", o_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_busy_end: got %b expected 0", rx_busy); end
  endtask

  task automatic test_framing();
    int dv0, fe0, b0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1600);
    repeat (30) @(negedge clk);
    b0 = busy_cnt;
    repeat (170) @(negedge clk);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL framing_fe_count: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL framing_dv: got %0d expected 0", dv_cnt - dv0); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL framing_data: got %h expected a5", o_data); end
    checks++; if (busy_cnt - b0 !== 0) begin errors++; $display("FAIL break_retrigger: got %0d busy cycles expected 0", busy_cnt - b0); end
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dv0, fe0;
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_frame(8'h00, 1'b1, 1600);
    send_frame(8'hFF, 1'b1, 1632);
    send_frame(8'h3C, 1'b1, 1568);
    repeat (30) @(negedge clk);
    checks++; if (dv_cnt - dv0 !== 3) begin errors++; $display("FAIL b2b_dv_count: got %0d expected 3", dv_cnt - dv0); end
    checks++; if (dv_log[dv0] !== 8'h00) begin errors++; $display("FAIL b2b_word0: got %h expected 00", dv_log[dv0]); end
    checks++; if (dv_log[dv0 + 1] !== 8'hFF) begin errors++; $display("FAIL b2b_word1: got %h expected ff", dv_log[dv0 + 1]); end
    checks++; if (dv_log[dv0 + 2] !== 8'h3C) begin errors++; $display("FAIL b2b_word2: got %h expected 3c", dv_log[dv0 + 2]); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL b2b_fe: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_reset_mid_frame();
    int dv0, fe0;
    logic [2:0] first_bits;
    first_bits = 3'b001;
    dv0 = dv_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx = first_bits[k];
      repeat (16) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
    @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL midrst_dv: got %0d expected 0", dv_cnt - dv0); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL midrst_fe: got %0d expected 0", fe_cnt - fe0); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL midrst_data_cleared: got %h expected 00", o_data); end
    send_frame(8'h5A, 1'b1, 1600);
    repeat (20) @(negedge clk);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL midrst_after_dv: got %0d expected 1", dv_cnt - dv0); end
    checks++; if (o_data !== 8'h5A) begin errors++; $display("FAIL midrst_after_data: got %h expected 5a", o_data); end
  endtask

  task automatic test_pulse_rules();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d cycles expected 0", both_cnt); end
    checks++; if (long_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses expected 0", long_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    test_pulse_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
